// File: rtl/mips_cpu_div_ctrl.sv
// Divide controller: issues DIV/DIVU to an unsigned start/done divider, applies sign fix-up and owns HI/LO.
// Optional WAIT watchdog is enabled by defining MIPS_CPU_DIV_TIMEOUT_EN.
module mips_cpu_div_ctrl #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             op_valid_i,
    input  logic             op_signed_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             mthi_en_i,
    input  logic             mtlo_en_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             mf_req_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             stall_o,
    output logic             dbz_o,
    output logic             div_start_o,
    output logic [WIDTH-1:0] div_dividend_o,
    output logic [WIDTH-1:0] div_divisor_o,
    input  logic [WIDTH-1:0] div_quotient_i,
    input  logic [WIDTH-1:0] div_remainder_i,
    input  logic             div_done_i,
    input  logic             div_dbz_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        FIX   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             dbz_q, dbz_d;

`ifdef MIPS_CPU_DIV_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            dbz_q      <= 1'b0;
`ifdef MIPS_CPU_DIV_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            dbz_q      <= dbz_d;
`ifdef MIPS_CPU_DIV_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        dbz_d      = 1'b0;
`ifdef MIPS_CPU_DIV_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                // MTHI/MTLO land even when a division is launched in the same cycle.
                if (mthi_en_i) hi_d = wdata_i;
                if (mtlo_en_i) lo_d = wdata_i;
                if (op_valid_i) begin
                    if (op_b_i == '0) begin
                        dbz_d = 1'b1;
                    end else begin
                        sa_d       = op_signed_i & op_a_i[WIDTH-1];
                        sb_d       = op_signed_i & op_b_i[WIDTH-1];
                        dividend_d = (op_signed_i & op_a_i[WIDTH-1]) ? ('0 - op_a_i) : op_a_i;
                        divisor_d  = (op_signed_i & op_b_i[WIDTH-1]) ? ('0 - op_b_i) : op_b_i;
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef MIPS_CPU_DIV_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (div_done_i) begin
                    if (div_dbz_i) begin
                        dbz_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        quot_d  = div_quotient_i;
                        rem_d   = div_remainder_i;
                        state_d = FIX;
                    end
                end
`ifdef MIPS_CPU_DIV_TIMEOUT_EN
                else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    dbz_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            FIX: begin
                // Quotient sign follows sa^sb, remainder follows the dividend; -2^(W-1)/-1 wraps.
                lo_d    = (sa_q ^ sb_q) ? ('0 - quot_q) : quot_q;
                hi_d    = sa_q ? ('0 - rem_q) : rem_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o         = (state_q != IDLE);
    assign stall_o        = busy_o & (op_valid_i | mf_req_i | mthi_en_i | mtlo_en_i);
    assign div_start_o    = (state_q == ISSUE);
    assign dbz_o          = dbz_q;
    assign hi_o           = hi_q;
    assign lo_o           = lo_q;
    assign div_dividend_o = dividend_q;
    assign div_divisor_o  = divisor_q;

endmodule
